// File: rtl/demux4_stream_if.sv
// Stream bus for the 1-to-4 distributor: one producer side, four consumer channels.
// Optional macro DEMUX4_STREAM_COUNT_EN adds the per-channel delivery counter field.
interface demux4_stream_if #(
   parameter int N = 4
);
   logic [N-1:0] in_data;
   logic [1:0]   in_select;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] out0;
   logic [N-1:0] out1;
   logic [N-1:0] out2;
   logic [N-1:0] out3;
   logic [3:0]   out_valid;
   logic [3:0]   out_ready;
   logic [2:0]   occupancy;
`ifdef DEMUX4_STREAM_COUNT_EN
   logic [31:0]  count;
`endif

   // Drives the producer inputs and consumer readies, observes everything else.
   modport master (
      output in_data, in_select, in_valid, out_ready,
      input  in_ready, out0, out1, out2, out3, out_valid, occupancy
`ifdef DEMUX4_STREAM_COUNT_EN
      , input count
`endif
   );

   modport slave (
      input  in_data, in_select, in_valid, out_ready,
      output in_ready, out0, out1, out2, out3, out_valid, occupancy
`ifdef DEMUX4_STREAM_COUNT_EN
      , output count
`endif
   );
endinterface

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream distributor with a one-entry holding slot per channel.
// Optional macro DEMUX4_STREAM_COUNT_EN adds saturating 8-bit delivery counters per channel.
module demux4_stream #(
   parameter int N = 4
) (
   input logic           clk,
   input logic           rst_n,
   demux4_stream_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

   slot_state_e  state_q [4];
   slot_state_e  state_d [4];
   logic [N-1:0] data_q  [4];
   logic [3:0]   valid_q;
   logic [3:0]   valid_d;
   logic [3:0]   accept_k;
   logic [2:0]   occ_q;
   logic [2:0]   occ_d;
   logic         in_ready;
   logic         accept;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         valid_q[k] = (state_q[k] == FULL);
      end
   end

   // A stalled slot only blocks words addressed to it; readiness never looks at in_valid.
   assign in_ready = rst_n && (!valid_q[bus.in_select] || bus.out_ready[bus.in_select]);
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         accept_k[k] = accept && (bus.in_select == 2'(k));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= EMPTY;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
         end
      end
   end

   // A simultaneous drain and accept keeps the slot FULL with the new word.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         case (state_q[k])
            EMPTY:   if (accept_k[k]) state_d[k] = FULL;
            FULL:    if (!accept_k[k] && bus.out_ready[k]) state_d[k] = EMPTY;
            default: state_d[k] = EMPTY;
         endcase
      end
   end

   always_comb begin
      occ_d = '0;
      for (int k = 0; k < 4; k++) begin
         valid_d[k] = (state_d[k] == FULL);
         occ_d      = occ_d + 3'(valid_d[k]);
      end
   end

   always_comb begin
      bus.in_ready  = in_ready;
      bus.out_valid = valid_q;
      bus.out0      = data_q[0];
      bus.out1      = data_q[1];
      bus.out2      = data_q[2];
      bus.out3      = data_q[3];
      bus.occupancy = occ_q;
   end

   // Empty slots keep their last word; only an accept to a slot rewrites it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= '0;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         occ_q <= occ_d;
         for (int k = 0; k < 4; k++) begin
            if (accept_k[k]) data_q[k] <= bus.in_data;
         end
      end
   end

`ifdef DEMUX4_STREAM_COUNT_EN
   logic [7:0] cnt_q [4];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (valid_q[k] && bus.out_ready[k] && (cnt_q[k] != 8'hFF)) begin
               cnt_q[k] <= cnt_q[k] + 8'd1;
            end
         end
      end
   end

   assign bus.count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif
endmodule

// File: tb/tb_demux4_stream.sv
// Directed plus randomized bench for demux4_stream against a slot-level reference model.
// Build with DEMUX4_STREAM_COUNT_EN to also exercise the delivery counters.
module tb_demux4_stream;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   bit           m_valid [4];
   logic [N-1:0] m_data  [4];
   int           m_cnt   [4];

   always #5 clk = ~clk;

   demux4_stream_if #(.N(N)) bus ();

   demux4_stream #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic expReady();
      return rst_n && (!m_valid[bus.in_select] || bus.out_ready[bus.in_select]);
   endfunction

   // Every output is compared with the model state left by the previous edge.
   task automatic checkOutput();
      logic [3:0] vec;
      int occ;
      occ = 0;
      for (int k = 0; k < 4; k++) begin
         vec[k] = m_valid[k];
         occ += int'(m_valid[k]);
      end
      compare("in_ready", 32'(bus.in_ready), 32'(expReady()));
      compare("out_valid", 32'(bus.out_valid), 32'(vec));
      compare("occupancy", 32'(bus.occupancy), 32'(occ));
      compare("out0", 32'(bus.out0), 32'(m_data[0]));
      compare("out1", 32'(bus.out1), 32'(m_data[1]));
      compare("out2", 32'(bus.out2), 32'(m_data[2]));
      compare("out3", 32'(bus.out3), 32'(m_data[3]));
`ifdef DEMUX4_STREAM_COUNT_EN
      compare("count", bus.count, {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
`endif
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [1:0] s,
                                input logic [N-1:0] d, input logic [3:0] rdy);
      logic acc;
      @(negedge clk);
      rst_n         = r;
      bus.in_valid  = v;
      bus.in_select = s;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #1;
      checkOutput();
      acc = v && expReady();
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         if (!r) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_cnt[k]   = 0;
         end else begin
            if (m_valid[k] && rdy[k] && m_cnt[k] < 255) m_cnt[k]++;
            if (acc && s == 2'(k)) begin
               m_valid[k] = 1'b1;
               m_data[k]  = d;
            end else if (m_valid[k] && rdy[k]) begin
               m_valid[k] = 1'b0;
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 4; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = '0;
         m_cnt[k]   = 0;
      end
      bus.in_valid  = 1'b1;
      bus.in_select = 2'd0;
      bus.in_data   = '0;
      bus.out_ready = 4'h0;
      @(posedge clk);

      $display("[TB] reset with in_valid held high");
      repeat (3) applyStimulus(1'b0, 1'b1, 2'd1, 8'hFF, 4'hF);

      $display("[TB] fan-out to all four channels");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b1, 2'(k), 8'hA0 + 8'(k), 4'hF);
         #1;
         compare("fanout_onehot", 32'(bus.out_valid), 32'(4'b0001 << k));
      end
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);

      $display("[TB] backpressure on channel 2");
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h11, 4'h0);
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h22, 4'h0);
      #1;
      compare("bp_hold_out2", 32'(bus.out2), 32'h11);
      compare("bp_occupancy", 32'(bus.occupancy), 32'd1);
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h22, 4'b0100);
      #1;
      compare("bp_replace_out2", 32'(bus.out2), 32'h22);

      $display("[TB] stalled channel does not block others");
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
      applyStimulus(1'b1, 1'b1, 2'd1, 8'h44, 4'h0);
      applyStimulus(1'b1, 1'b1, 2'd3, 8'h33, 4'h0);
      #1;
      compare("nb_out3", 32'(bus.out3), 32'h33);
      compare("nb_out1", 32'(bus.out1), 32'h44);
      compare("nb_occupancy", 32'(bus.occupancy), 32'd2);

      $display("[TB] all channels full");
      applyStimulus(1'b1, 1'b1, 2'd0, 8'h50, 4'h0);
      applyStimulus(1'b1, 1'b1, 2'd2, 8'h52, 4'h0);
      for (int s = 0; s < 4; s++) applyStimulus(1'b1, 1'b1, 2'(s), 8'h60 + 8'(s), 4'h0);
      #1;
      compare("full_occupancy", 32'(bus.occupancy), 32'd4);
      compare("full_out0", 32'(bus.out0), 32'h50);
      applyStimulus(1'b1, 1'b1, 2'd0, 8'h77, 4'b0001);
      #1;
      compare("swap_occupancy", 32'(bus.occupancy), 32'd4);
      compare("swap_out0", 32'(bus.out0), 32'h77);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(39) != 0), 1'($urandom), 2'($urandom),
                       N'($urandom), 4'($urandom));
      end

`ifdef DEMUX4_STREAM_COUNT_EN
      $display("[TB] delivery counter saturation");
      applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 4'h0);
      for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 2'd1, 8'(i), 4'b0010);
      #1;
      compare("count_saturated", bus.count, 32'h0000FF00);
      applyStimulus(1'b0, 1'b1, 2'd1, 8'h00, 4'b0010);
      #1;
      compare("count_cleared", bus.count, 32'h0);
`endif

      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 4'hF);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
